jtag_uart_avalon_responder: RTL and testbench

Avalon-MM slave that models the JTAG UART's two-register interface. It is the responder to the on-chip Avalon master that runs the H/A handshake. It buffers bytes from a host-side byte stream into an RX FIFO and buffers master writes into a TX FIFO drained by a host-side stream. It is used as a synthesizable stand-in for the vendor IP in simulation and in loopback builds, and its register map and waitrequest behaviour match the real JTAG UART.

---
 rtl/jtag_uart_avalon_responder.sv | 175 +++++++++++++++++
 tb/tb_jtag_uart_avalon_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_uart_avalon_responder.sv
// Avalon-MM slave modelling the JTAG UART DATA/CONTROL register pair,
// with an RX FIFO filled from the host stream and a TX FIFO drained by it.
module jtag_uart_avalon_responder #(
    parameter int RX_DEPTH    = 16,
    parameter int TX_DEPTH    = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        av_chipselect,
    input  logic        av_address,
    input  logic        av_read_n,
    input  logic        av_write_n,
    input  logic [31:0] av_writedata,
    output logic [31:0] av_readdata,
    output logic        av_waitrequest,
    output logic        irq,
    input  logic        host_rx_valid,
    input  logic [7:0]  host_rx_data,
    output logic        host_rx_ready,
    output logic        host_tx_valid,
    output logic [7:0]  host_tx_data,
    input  logic        host_tx_ready
);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int RX_CW = RX_AW + 1;
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int TX_CW = TX_AW + 1;
    localparam logic [RX_CW-1:0] RX_FULL = RX_CW'(RX_DEPTH);
    localparam logic [TX_CW-1:0] TX_FULL = TX_CW'(TX_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    logic [1:0]       r_state;
    logic [3:0]       r_wcnt;
    logic             r_re, r_we, r_ac;
    logic [7:0]       r_rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] r_rx_wr, r_rx_rd;
    logic [RX_CW-1:0] r_rx_count;
    logic [7:0]       r_tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] r_tx_wr, r_tx_rd;
    logic [TX_CW-1:0] r_tx_count;

    logic             w_acc, w_rd, w_wr, w_commit, w_ctl_wr;
    logic             w_rx_push, w_rx_pop, w_tx_push, w_tx_pop;
    logic             w_ri, w_wi;
    logic [TX_CW-1:0] w_wspace;
    logic [RX_CW-1:0] w_ravail;
    logic             w_unused;

    // Both strobes low is treated as a read.
    assign w_acc    = av_chipselect & (~av_read_n | ~av_write_n);
    assign w_rd     = ~av_read_n;
    assign w_wr     = av_read_n & ~av_write_n;
    assign w_commit = (r_state == S_ACK) & w_acc;
    assign w_ctl_wr = w_commit & w_wr & av_address;
    assign w_unused = ^{av_writedata[31:11], av_writedata[9:8]};

    assign av_waitrequest = w_acc & (r_state != S_ACK);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_wcnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_acc) begin
                    r_state <= S_WAIT;
                    r_wcnt  <= 4'(WAIT_CYCLES - 1);
                end
                S_WAIT: begin
                    if (!w_acc)
                        r_state <= S_IDLE;
                    else if (r_wcnt == 4'd0)
                        r_state <= S_ACK;
                    else
                        r_wcnt <= r_wcnt - 4'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign host_rx_ready = (r_rx_count != RX_FULL);
    assign w_rx_push     = host_rx_valid & host_rx_ready;
    assign w_rx_pop      = w_commit & w_rd & ~av_address & (r_rx_count != '0);

    always_ff @(posedge clk) begin
        if (w_rx_push)
            r_rx_mem[r_rx_wr] <= host_rx_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_wr    <= '0;
            r_rx_rd    <= '0;
            r_rx_count <= '0;
        end else begin
            if (w_rx_push)
                r_rx_wr <= r_rx_wr + RX_AW'(1);
            if (w_rx_pop)
                r_rx_rd <= r_rx_rd + RX_AW'(1);
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + RX_CW'(1);
                2'b01:   r_rx_count <= r_rx_count - RX_CW'(1);
                default: r_rx_count <= r_rx_count;
            endcase
        end
    end

    assign host_tx_valid = (r_tx_count != '0);
    assign host_tx_data  = host_tx_valid ? r_tx_mem[r_tx_rd] : 8'h00;
    assign w_tx_pop      = host_tx_valid & host_tx_ready;
    // A DATA write into a full TX FIFO is silently dropped.
    assign w_tx_push     = w_commit & w_wr & ~av_address & (r_tx_count != TX_FULL);

    always_ff @(posedge clk) begin
        if (w_tx_push)
            r_tx_mem[r_tx_wr] <= av_writedata[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_wr    <= '0;
            r_tx_rd    <= '0;
            r_tx_count <= '0;
        end else begin
            if (w_tx_push)
                r_tx_wr <= r_tx_wr + TX_AW'(1);
            if (w_tx_pop)
                r_tx_rd <= r_tx_rd + TX_AW'(1);
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_count <= r_tx_count + TX_CW'(1);
                2'b01:   r_tx_count <= r_tx_count - TX_CW'(1);
                default: r_tx_count <= r_tx_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_re <= 1'b0;
            r_we <= 1'b0;
            r_ac <= 1'b0;
        end else begin
            if (w_ctl_wr) begin
                r_re <= av_writedata[0];
                r_we <= av_writedata[1];
            end
            // A host pop in the same cycle as an AC clear keeps AC set.
            if (w_tx_pop)
                r_ac <= 1'b1;
            else if (w_ctl_wr && av_writedata[10])
                r_ac <= 1'b0;
        end
    end

    assign w_wspace = TX_FULL - r_tx_count;
    assign w_ravail = r_rx_count - RX_CW'(1);
    assign w_ri     = r_re & (r_rx_count != '0);
    assign w_wi     = r_we & (w_wspace != '0);
    assign irq      = w_ri | w_wi;

    always_comb begin
        av_readdata = '0;
        if (r_state == S_ACK) begin
            if (av_address)
                av_readdata = {16'(w_wspace), 5'b0, r_ac, w_wi, w_ri, 6'b0, r_we, r_re};
            else if (r_rx_count != '0)
                av_readdata = {16'(w_ravail), 1'b1, 7'b0, r_rx_mem[r_rx_rd]};
        end
    end
endmodule

// File: tb/tb_jtag_uart_avalon_responder.sv
// Directed, table-driven bench for jtag_uart_avalon_responder at default parameters.
module tb_jtag_uart_avalon_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        av_chipselect, av_address, av_read_n, av_write_n;
    logic [31:0] av_writedata, av_readdata;
    logic        av_waitrequest, irq;
    logic        host_rx_valid, host_rx_ready;
    logic [7:0]  host_rx_data;
    logic        host_tx_valid, host_tx_ready;
    logic [7:0]  host_tx_data;

    int checks   = 0;
    int failures = 0;

    localparam int K_RD = 0, K_WR = 1, K_PUSH = 2, K_POP = 3;

    typedef struct {
        int          kind;
        logic        addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic        exp_irq;
        logic        exp_txv;
        logic [7:0]  exp_txd;
    } vec_t;

    vec_t tbl[$];

    jtag_uart_avalon_responder #(.RX_DEPTH(16), .TX_DEPTH(16), .WAIT_CYCLES(1)) dut (
        .clk(clk), .reset(reset),
        .av_chipselect(av_chipselect), .av_address(av_address),
        .av_read_n(av_read_n), .av_write_n(av_write_n),
        .av_writedata(av_writedata), .av_readdata(av_readdata),
        .av_waitrequest(av_waitrequest), .irq(irq),
        .host_rx_valid(host_rx_valid), .host_rx_data(host_rx_data),
        .host_rx_ready(host_rx_ready),
        .host_tx_valid(host_tx_valid), .host_tx_data(host_tx_data),
        .host_tx_ready(host_tx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        av_chipselect = 1'b0;
        av_read_n     = 1'b1;
        av_write_n    = 1'b1;
        av_address    = 1'b0;
        av_writedata  = '0;
    endtask

    // Called #1 after a rising edge; returns #1 after the committing edge.
    task automatic access(input logic addr, input logic wr, input logic [31:0] wd,
                          output logic [31:0] rd);
        int  lat;
        bit  done;
        lat  = 0;
        done = 0;
        rd   = '0;
        av_chipselect = 1'b1;
        av_address    = addr;
        av_read_n     = wr;
        av_write_n    = ~wr;
        av_writedata  = wd;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (!av_waitrequest) begin
                rd   = av_readdata;
                done = 1;
            end else begin
                lat++;
            end
        end
        chk("latency", 32'(lat), 32'd2);
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic push(input logic [7:0] b);
        host_rx_valid = 1'b1;
        host_rx_data  = b;
        @(posedge clk); #1;
        host_rx_valid = 1'b0;
    endtask

    task automatic pop();
        host_tx_ready = 1'b1;
        @(posedge clk); #1;
        host_tx_ready = 1'b0;
    endtask

    task automatic add(input int k, input logic a, input logic [31:0] d, input logic [31:0] e,
                       input logic ei, input logic ev, input logic [7:0] et);
        vec_t v;
        v.kind = k; v.addr = a; v.data = d; v.exp_rd = e;
        v.exp_irq = ei; v.exp_txv = ev; v.exp_txd = et;
        tbl.push_back(v);
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  b;

        bus_idle();
        host_rx_valid = 1'b0;
        host_rx_data  = '0;
        host_tx_ready = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_readdata", av_readdata, 32'h0);
        chk("rst_waitreq", 32'(av_waitrequest), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_txv", 32'(host_tx_valid), 32'h0);
        chk("rst_txd", 32'(host_tx_data), 32'h0);
        chk("rst_rxready", 32'(host_rx_ready), 32'h1);
        reset = 1'b0;
        @(posedge clk); #1;

        add(K_RD,   1, 0,         32'h0010_0000, 0, 0, 8'h00);
        add(K_PUSH, 0, 32'h48,    0,             0, 0, 8'h00);
        add(K_RD,   0, 0,         32'h0000_8048, 0, 0, 8'h00);
        add(K_RD,   0, 0,         32'h0000_0000, 0, 0, 8'h00);
        add(K_WR,   0, 32'h41,    0,             0, 1, 8'h41);
        add(K_RD,   1, 0,         32'h000F_0000, 0, 1, 8'h41);
        add(K_POP,  0, 0,         0,             0, 0, 8'h00);
        add(K_RD,   1, 0,         32'h0010_0400, 0, 0, 8'h00);
        add(K_WR,   1, 32'h400,   0,             0, 0, 8'h00);
        add(K_RD,   1, 0,         32'h0010_0000, 0, 0, 8'h00);
        add(K_WR,   1, 32'h3,     0,             1, 0, 8'h00);
        add(K_RD,   1, 0,         32'h0010_0203, 1, 0, 8'h00);
        add(K_PUSH, 0, 32'h55,    0,             1, 0, 8'h00);
        add(K_RD,   1, 0,         32'h0010_0303, 1, 0, 8'h00);
        add(K_WR,   1, 32'h1,     0,             1, 0, 8'h00);
        add(K_RD,   1, 0,         32'h0010_0101, 1, 0, 8'h00);
        add(K_RD,   0, 0,         32'h0000_8055, 0, 0, 8'h00);
        add(K_WR,   1, 32'h0,     0,             0, 0, 8'h00);

        foreach (tbl[i]) begin
            case (tbl[i].kind)
                K_RD: begin
                    access(tbl[i].addr, 1'b0, '0, rd);
                    chk($sformatf("vec%0d_rd", i), rd, tbl[i].exp_rd);
                end
                K_WR:    access(tbl[i].addr, 1'b1, tbl[i].data, rd);
                K_PUSH:  push(tbl[i].data[7:0]);
                default: pop();
            endcase
            chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(tbl[i].exp_irq));
            chk($sformatf("vec%0d_txv", i), 32'(host_tx_valid), 32'(tbl[i].exp_txv));
            chk($sformatf("vec%0d_txd", i), 32'(host_tx_data), 32'(tbl[i].exp_txd));
        end

        // TX overflow: 17th byte dropped, 16 drain in order.
        for (int i = 0; i < 17; i++) access(1'b0, 1'b1, 32'h10 + 32'(i), rd);
        access(1'b1, 1'b0, '0, rd);
        chk("tx_full_ctl", rd, 32'h0000_0000);
        for (int i = 0; i < 16; i++) begin
            b = 8'h10 + 8'(i);
            chk($sformatf("tx_drain%0d_v", i), 32'(host_tx_valid), 32'h1);
            chk($sformatf("tx_drain%0d_d", i), 32'(host_tx_data), 32'(b));
            pop();
        end
        chk("tx_empty", 32'(host_tx_valid), 32'h0);
        access(1'b1, 1'b0, '0, rd);
        chk("tx_ac_set", rd, 32'h0010_0400);
        access(1'b1, 1'b1, 32'h400, rd);

        // RX full, then pop with host byte waiting.
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
        chk("rx_full_ready", 32'(host_rx_ready), 32'h0);
        access(1'b1, 1'b1, 32'h1, rd);
        chk("rx_full_irq", 32'(irq), 32'h1);
        access(1'b1, 1'b0, '0, rd);
        chk("rx_full_ctl", rd, 32'h0010_0101);
        host_rx_valid = 1'b1;
        host_rx_data  = 8'h30;
        access(1'b0, 1'b0, '0, rd);
        chk("rx_full_pop", rd, 32'h000F_8020);
        @(posedge clk); #1;
        host_rx_valid = 1'b0;
        chk("rx_refull_ready", 32'(host_rx_ready), 32'h0);
        for (int i = 0; i < 16; i++) begin
            b = (i < 15) ? 8'h21 + 8'(i) : 8'h30;
            access(1'b0, 1'b0, '0, rd);
            chk($sformatf("rx_drain%0d", i), rd, {16'(15 - i), 8'h80, b});
        end
        access(1'b0, 1'b0, '0, rd);
        chk("rx_drained", rd, 32'h0);
        access(1'b1, 1'b1, 32'h0, rd);
        chk("rx_drained_irq", 32'(irq), 32'h0);

        // Host push lands in the same cycle as a DATA-read pop.
        push(8'h61);
        av_chipselect = 1'b1; av_address = 1'b0; av_read_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        host_rx_valid = 1'b1;
        host_rx_data  = 8'h62;
        @(negedge clk);
        chk("sim_wr", 32'(av_waitrequest), 32'h0);
        chk("sim_rd", av_readdata, 32'h0000_8061);
        @(posedge clk); #1;
        host_rx_valid = 1'b0;
        bus_idle();
        access(1'b0, 1'b0, '0, rd);
        chk("sim_next", rd, 32'h0000_8062);
        access(1'b0, 1'b0, '0, rd);
        chk("sim_empty", rd, 32'h0);

        // Abort in WAIT leaves RX untouched.
        push(8'h71);
        av_chipselect = 1'b1; av_address = 1'b0; av_read_n = 1'b0;
        @(posedge clk); #1;
        bus_idle();
        @(posedge clk); #1;
        access(1'b0, 1'b0, '0, rd);
        chk("abort_rd", rd, 32'h0000_8071);

        // Reset in WAIT of a DATA read with 3 bytes queued.
        push(8'h81); push(8'h82); push(8'h83);
        access(1'b1, 1'b1, 32'h3, rd);
        av_chipselect = 1'b1; av_address = 1'b0; av_read_n = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_wr", 32'(av_waitrequest), 32'h1);
        chk("mid_rst_rd", av_readdata, 32'h0);
        chk("mid_rst_irq", 32'(irq), 32'h0);
        @(posedge clk); #1;
        chk("mid_rst_wr2", 32'(av_waitrequest), 32'h1);
        bus_idle();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        access(1'b1, 1'b0, '0, rd);
        chk("post_rst_ctl", rd, 32'h0010_0000);
        access(1'b0, 1'b0, '0, rd);
        chk("post_rst_data", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
